// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store funct3 codes,
// FSM state encoding and funct3 legality check.
package data_mem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Loads accept the five RV32I encodings; stores only the three signless sizes.
  function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    if (we) begin
      bad = (f3 > F3_W);
    end else begin
      bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end
    return bad;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between the core's load/store unit and the responder.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder_mem_lane_align.sv
// Byte-lane steering shared by store merge and load extraction, plus the
// size-based misalignment flag.
module mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic [31:0] wr_word,
  output logic [31:0] ld_data,
  output logic        misalign
);

  logic [7:0]  byte_sel_s;
  logic [15:0] half_sel_s;

  // Merge store lanes into the old word and extract/extend the load lanes.
  always_comb begin
    wr_word    = word;
    ld_data    = 32'd0;
    misalign   = 1'b0;
    byte_sel_s = word[{addr_lo, 3'b000} +: 8];
    if (addr_lo[1]) begin
      half_sel_s = word[31:16];
    end else begin
      half_sel_s = word[15:0];
    end
    case (funct3)
      F3_B, F3_BU: begin
        wr_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
        if (funct3[2]) begin
          ld_data = {24'd0, byte_sel_s};
        end else begin
          ld_data = {{24{byte_sel_s[7]}}, byte_sel_s};
        end
      end
      F3_H, F3_HU: begin
        misalign = addr_lo[0];
        wr_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
        if (funct3[2]) begin
          ld_data = {16'd0, half_sel_s};
        end else begin
          ld_data = {{16{half_sel_s[15]}}, half_sel_s};
        end
      end
      F3_W: begin
        misalign = |addr_lo;
        wr_word  = wdata;
        ld_data  = word;
      end
      default: begin
        misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store, waits LATENCY cycles,
// commits or reads the word array, then holds the response until it is taken.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                clk,
  input  logic                rst,
  data_mem_responder_if.slave bus
);

  localparam int         AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        req_ready_r, req_ready_s;
  logic        rsp_valid_r, rsp_valid_s;
  logic        accept_s, access_s;
  logic        we_r;
  logic [2:0]  f3_r;
  logic [31:0] addr_r, wdata_r;
  logic [31:0] rdata_r;
  logic        err_r;
  logic [31:0] mem_r [DEPTH_WORDS];
  logic [AW-1:0] idx_s;
  logic [31:0] word_s, wr_word_s, ld_data_s;
  logic        misalign_s, range_err_s, err_s;

  assign idx_s       = addr_r[AW+1:2];
  assign word_s      = mem_r[idx_s];
  assign range_err_s = 32'(addr_r[31:2]) >= 32'(DEPTH_WORDS);
  assign err_s       = misalign_s | range_err_s | funct3_illegal(we_r, f3_r);

  mem_lane_align u_align (
    .funct3  (f3_r),
    .addr_lo (addr_r[1:0]),
    .wdata   (wdata_r),
    .word    (word_s),
    .wr_word (wr_word_s),
    .ld_data (ld_data_s),
    .misalign(misalign_s)
  );

  // Next-state logic; handshake outputs are computed for the next cycle and registered.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    req_ready_s = 1'b0;
    rsp_valid_s = 1'b0;
    accept_s    = 1'b0;
    access_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req_valid && req_ready_r) begin
          accept_s = 1'b1;
          cnt_s    = LAT_M1;
          state_s  = WAIT;
        end else begin
          req_ready_s = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          access_s    = 1'b1;
          rsp_valid_s = 1'b1;
          state_s     = RESP;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready && rsp_valid_r) begin
          req_ready_s = 1'b1;
          state_s     = IDLE;
        end else begin
          rsp_valid_s = 1'b1;
        end
      end
      default: begin
        req_ready_s = 1'b1;
        state_s     = IDLE;
      end
    endcase
  end

  // State, counter, latched request and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      we_r        <= 1'b0;
      f3_r        <= 3'd0;
      addr_r      <= 32'd0;
      wdata_r     <= 32'd0;
      rdata_r     <= 32'd0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      req_ready_r <= req_ready_s;
      rsp_valid_r <= rsp_valid_s;
      if (accept_s) begin
        we_r    <= bus.req_we;
        f3_r    <= bus.req_funct3;
        addr_r  <= bus.req_addr;
        wdata_r <= bus.req_wdata;
      end
      if (access_s) begin
        rdata_r <= (err_s || we_r) ? 32'd0 : ld_data_s;
        err_r   <= err_s;
      end
    end
  end

  // Word array: contents survive reset; stores commit only on the WAIT->RESP edge.
  always_ff @(posedge clk) begin
    if (access_s && we_r && !err_s) begin
      mem_r[idx_s] <= wr_word_s;
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rdata_r;
  assign bus.rsp_err   = err_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised and directed checks of data_mem_responder against a byte-addressed
// reference model of RV32I load/store semantics.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  data_mem_responder_if bus();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;
  int cyc  = 0;
  int acc_q[$];
  logic [31:0] model_mem [DEPTH];

  // Edge index of every accepted request.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst && bus.req_valid && bus.req_ready) acc_q.push_back(cyc);
  end

  // Reference model: byte-addressed view of RV32I loads and stores.
  function automatic void model_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata, output logic [31:0] rdata,
                                   output logic err);
    int nb;
    int off;
    int w;
    logic [31:0] word;
    logic [31:0] v;
    logic [31:0] mask;
    case (f3)
      3'd0, 3'd4: nb = 1;
      3'd1, 3'd5: nb = 2;
      3'd2:       nb = 4;
      default:    nb = 0;
    endcase
    rdata = 32'd0;
    err   = 1'b0;
    if (nb == 0 || (we && f3 > 3'd2)) begin
      err = 1'b1;
    end else if ((addr % 32'(nb)) != 32'd0 || (addr >> 2) >= 32'(DEPTH)) begin
      err = 1'b1;
    end else begin
      off  = int'(addr[1:0]);
      w    = int'(addr >> 2);
      word = model_mem[w];
      if (we) begin
        for (int i = 0; i < nb; i++) word[8*(off+i) +: 8] = wdata[8*i +: 8];
        model_mem[w] = word;
      end else begin
        v = word >> (8 * off);
        if (nb < 4) begin
          mask = (32'd1 << (8 * nb)) - 32'd1;
          v = v & mask;
          if (!f3[2] && v[8*nb-1]) v = v | ~mask;
        end
        rdata = v;
      end
    end
  endfunction

  // Drive one request, wait for its response; handshakes it only if rsp_ready is high.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                     output int lat);
    int w = 0;
    @(negedge clk);
    bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && w < 50) begin @(negedge clk); w++; end
    if (w >= 50) begin
      ncmp++; nerr++;
      $display("FAIL txn_accept_timeout addr=%h req_ready stayed 0, required 1", addr);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'($urandom); bus.req_funct3 = 3'($urandom);
    bus.req_addr = $urandom; bus.req_wdata = $urandom;
    lat = 0;
    while (!bus.rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!bus.rsp_valid) begin
      ncmp++; nerr++;
      $display("FAIL txn_rsp_timeout addr=%h rsp_valid stayed 0, required 1", addr);
    end
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    if (bus.rsp_ready) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    #12;
    ncmp++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_handshake got ready=%b valid=%b, required 1/0", bus.req_ready, bus.rsp_valid);
    end
    ncmp++;
    if (bus.rsp_rdata !== 32'd0 || bus.rsp_err !== 1'b0) begin
      nerr++;
      $display("FAIL reset_rsp got rdata=%h err=%b, required 0/0", bus.rsp_rdata, bus.rsp_err);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic init_region();
    logic [31:0] r; logic e; int l;
    for (int i = 0; i < 64; i++) begin
      txn(1'b1, F3_W, 32'(4*i), 32'd0, r, e, l);
      model_op(1'b1, F3_W, 32'(4*i), 32'd0, r, e);
    end
  endtask

  task automatic test_word();
    logic [31:0] r, mr; logic e, me; int l;
    txn(1'b1, F3_W, 32'h10, 32'hDEADBEEF, r, e, l);
    model_op(1'b1, F3_W, 32'h10, 32'hDEADBEEF, mr, me);
    ncmp++;
    if (l !== LAT || e !== 1'b0 || r !== 32'd0) begin
      nerr++;
      $display("FAIL sw_word got lat=%0d err=%b rdata=%h, required %0d/0/0", l, e, r, LAT);
    end
    txn(1'b0, F3_W, 32'h10, 32'h0, r, e, l);
    ncmp++;
    if (l !== LAT || e !== 1'b0 || r !== 32'hDEADBEEF) begin
      nerr++;
      $display("FAIL lw_word got lat=%0d err=%b rdata=%h, required %0d/0/deadbeef", l, e, r, LAT);
    end
  endtask

  task automatic test_byte();
    logic [31:0] r, mr; logic e, me; int l;
    txn(1'b1, F3_W, 32'h10, 32'h0, r, e, l);
    model_op(1'b1, F3_W, 32'h10, 32'h0, mr, me);
    txn(1'b1, F3_B, 32'h11, 32'hABCDEF80, r, e, l);
    model_op(1'b1, F3_B, 32'h11, 32'hABCDEF80, mr, me);
    txn(1'b0, F3_B, 32'h11, 32'h0, r, e, l);
    ncmp++;
    if (r !== 32'hFFFFFF80 || e !== 1'b0) begin
      nerr++; $display("FAIL lb_signext got %h err=%b, required ffffff80/0", r, e);
    end
    txn(1'b0, F3_BU, 32'h11, 32'h0, r, e, l);
    ncmp++;
    if (r !== 32'h00000080 || e !== 1'b0) begin
      nerr++; $display("FAIL lbu_zeroext got %h err=%b, required 00000080/0", r, e);
    end
    txn(1'b0, F3_W, 32'h10, 32'h0, r, e, l);
    ncmp++;
    if (r !== 32'h00008000) begin
      nerr++; $display("FAIL sb_lane_merge got %h, required 00008000", r);
    end
  endtask

  task automatic test_half();
    logic [31:0] r, mr; logic e, me; int l;
    txn(1'b1, F3_W, 32'h20, 32'h0, r, e, l);
    model_op(1'b1, F3_W, 32'h20, 32'h0, mr, me);
    txn(1'b1, F3_H, 32'h22, 32'h12348001, r, e, l);
    model_op(1'b1, F3_H, 32'h22, 32'h12348001, mr, me);
    txn(1'b0, F3_H, 32'h22, 32'h0, r, e, l);
    ncmp++;
    if (r !== 32'hFFFF8001 || e !== 1'b0) begin
      nerr++; $display("FAIL lh_signext got %h err=%b, required ffff8001/0", r, e);
    end
    txn(1'b0, F3_HU, 32'h22, 32'h0, r, e, l);
    ncmp++;
    if (r !== 32'h00008001 || e !== 1'b0) begin
      nerr++; $display("FAIL lhu_zeroext got %h err=%b, required 00008001/0", r, e);
    end
    txn(1'b0, F3_H, 32'h21, 32'h0, r, e, l);
    ncmp++;
    if (r !== 32'd0 || e !== 1'b1 || l !== LAT) begin
      nerr++; $display("FAIL lh_misaligned got %h err=%b lat=%0d, required 0/1/%0d", r, e, l, LAT);
    end
  endtask

  task automatic test_errors();
    logic [31:0] r, mr; logic e, me; int l;
    txn(1'b1, F3_W, 32'h0, 32'h11111111, r, e, l);
    model_op(1'b1, F3_W, 32'h0, 32'h11111111, mr, me);
    txn(1'b1, F3_W, 32'h1000, 32'h22222222, r, e, l);
    ncmp++;
    if (e !== 1'b1 || r !== 32'd0 || l !== LAT) begin
      nerr++; $display("FAIL sw_out_of_range got err=%b rdata=%h lat=%0d, required 1/0/%0d", e, r, l, LAT);
    end
    txn(1'b0, F3_W, 32'h0, 32'h0, r, e, l);
    ncmp++;
    if (r !== 32'h11111111) begin
      nerr++; $display("FAIL array_unchanged got %h, required 11111111", r);
    end
    txn(1'b0, 3'b011, 32'h10, 32'h0, r, e, l);
    ncmp++;
    if (e !== 1'b1 || r !== 32'd0) begin
      nerr++; $display("FAIL load_f3_011 got err=%b rdata=%h, required 1/0", e, r);
    end
    txn(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, r, e, l);
    txn(1'b0, F3_W, 32'h12, 32'h0, r, e, l);
    ncmp++;
    if (e !== 1'b1 || r !== 32'd0) begin
      nerr++; $display("FAIL lw_misaligned got err=%b rdata=%h, required 1/0", e, r);
    end
    txn(1'b0, F3_W, 32'h10, 32'h0, r, e, l);
    model_op(1'b0, F3_W, 32'h10, 32'h0, mr, me);
    ncmp++;
    if (r !== mr || e !== 1'b0) begin
      nerr++; $display("FAIL store_f3_100_no_write got %h err=%b, required %h/0", r, e, mr);
    end
  endtask

  task automatic test_stall();
    logic [31:0] r, mr; logic e, me; int l; int n0; int w;
    bus.rsp_ready = 1'b0;
    model_op(1'b0, F3_W, 32'h10, 32'h0, mr, me);
    txn(1'b0, F3_W, 32'h10, 32'h0, r, e, l);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_W;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h55AA55AA;
    n0 = acc_q.size();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      ncmp++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== mr || bus.req_ready !== 1'b0) begin
        nerr++;
        $display("FAIL stall_hold cyc%0d got valid=%b rdata=%h ready=%b, required 1/%h/0",
                 i, bus.rsp_valid, bus.rsp_rdata, bus.req_ready, mr);
      end
    end
    @(negedge clk); bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    ncmp++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || acc_q.size() !== n0) begin
      nerr++;
      $display("FAIL stall_release got valid=%b ready=%b accepts=%0d, required 0/1/%0d",
               bus.rsp_valid, bus.req_ready, acc_q.size(), n0);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    ncmp++;
    if (acc_q.size() !== n0 + 1 || bus.req_ready !== 1'b0) begin
      nerr++;
      $display("FAIL stall_next_accept got accepts=%0d ready=%b, required %0d/0",
               acc_q.size(), bus.req_ready, n0 + 1);
    end
    model_op(1'b1, F3_W, 32'h10, 32'h55AA55AA, mr, me);
    w = 0;
    while (!bus.rsp_valid && w < 50) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    txn(1'b0, F3_W, 32'h10, 32'h0, r, e, l);
    ncmp++;
    if (r !== 32'h55AA55AA) begin
      nerr++; $display("FAIL stall_store_commit got %h, required 55aa55aa", r);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r, mr; logic e, me; int l;
    txn(1'b1, F3_W, 32'h40, 32'h0BADF00D, r, e, l);
    model_op(1'b1, F3_W, 32'h40, 32'h0BADF00D, mr, me);
    txn(1'b0, F3_W, 32'h40, 32'h0, r, e, l);
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_funct3 = F3_W; bus.req_addr = 32'h40;
    bus.req_wdata = 32'hFFFFFFFF; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b0;
    #1;
    ncmp++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'd0 || bus.rsp_err !== 1'b0) begin
      nerr++;
      $display("FAIL reset_mid_outputs got ready=%b valid=%b rdata=%h err=%b, required 1/0/0/0",
               bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    txn(1'b0, F3_W, 32'h40, 32'h0, r, e, l);
    ncmp++;
    if (r !== 32'h0BADF00D) begin
      nerr++; $display("FAIL reset_drops_store got %h, required 0badf00d", r);
    end
    bus.rsp_ready = 1'b0;
    txn(1'b1, F3_W, 32'h44, 32'h600DCAFE, r, e, l);
    model_op(1'b1, F3_W, 32'h44, 32'h600DCAFE, mr, me);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1; bus.rsp_ready = 1'b1;
    txn(1'b0, F3_W, 32'h44, 32'h0, r, e, l);
    ncmp++;
    if (r !== 32'h600DCAFE) begin
      nerr++; $display("FAIL reset_keeps_commit got %h, required 600dcafe", r);
    end
  endtask

  task automatic test_back_to_back();
    int n0; int w;
    @(negedge clk);
    bus.req_we = 1'b0; bus.req_funct3 = F3_W; bus.req_addr = 32'h10; bus.req_valid = 1'b1;
    n0 = acc_q.size();
    repeat (4 * (LAT + 2)) @(posedge clk);
    @(negedge clk); bus.req_valid = 1'b0;
    ncmp++;
    if (acc_q.size() - n0 !== 4) begin
      nerr++; $display("FAIL b2b_count got %0d accepts, required 4", acc_q.size() - n0);
    end
    for (int i = n0; i + 1 < acc_q.size(); i++) begin
      ncmp++;
      if (acc_q[i+1] - acc_q[i] !== LAT + 2) begin
        nerr++; $display("FAIL b2b_spacing got %0d cycles, required %0d", acc_q[i+1] - acc_q[i], LAT + 2);
      end
    end
    w = 0;
    while (!bus.req_ready && w < 50) begin @(negedge clk); w++; end
  endtask

  task automatic test_random();
    logic [31:0] r, mr, addr, wd; logic e, me, we; logic [2:0] f3; int l;
    for (int i = 0; i < 60; i++) begin
      we   = 1'($urandom);
      f3   = 3'($urandom);
      addr = ($urandom_range(0, 9) == 0) ? 32'h1000 + 32'($urandom_range(0, 255))
                                         : 32'($urandom_range(0, 255));
      wd   = $urandom;
      model_op(we, f3, addr, wd, mr, me);
      txn(we, f3, addr, wd, r, e, l);
      ncmp++;
      if (r !== mr || e !== me || l !== LAT) begin
        nerr++;
        $display("FAIL random_%0d we=%b f3=%0d addr=%h got rdata=%h err=%b lat=%0d, required %h/%b/%0d",
                 i, we, f3, addr, r, e, l, mr, me, LAT);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.rsp_ready = 1'b1;
    test_reset();
    init_region();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
